// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: main entry plus one skid entry, valid/ready on both sides, synchronous flush.
// Optional load-use interlock and stall counter are enabled by defining LOAD_USE_STALL_EN.
module id_ex_stage_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_ex_ctrl,
  input  logic [6:0]        in_mem_ctrl,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_rs_val,
  input  logic [DATA_W-1:0] in_rt_val,
  input  logic [REG_AW-1:0] in_rs,
  input  logic [REG_AW-1:0] in_rt,
  input  logic [REG_AW-1:0] in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        out_ex_ctrl,
  output logic [6:0]        out_mem_ctrl,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_rs_val,
  output logic [DATA_W-1:0] out_rt_val,
  output logic [REG_AW-1:0] out_rd
`ifdef LOAD_USE_STALL_EN
  ,
  output logic [7:0]        stall_cnt
`endif
);

  localparam int CTRL_W = 12;
  localparam int ENT_W  = CTRL_W + 3 * DATA_W + REG_AW;

  logic [ENT_W-1:0] in_ent_s;
  logic [ENT_W-1:0] main_r;
  logic [ENT_W-1:0] skid_r;
  logic             main_valid_r;
  logic             skid_valid_r;
  logic             stall_s;
  logic             accept_s;
  logic             main_free_s;

  assign in_ent_s    = {in_ex_ctrl, in_mem_ctrl, in_pc, in_rs_val, in_rt_val, in_rd};
  assign in_ready    = !skid_valid_r && !stall_s;
  assign accept_s    = in_valid && in_ready;
  assign main_free_s = !main_valid_r || out_ready;

  // Outputs come straight from the main entry; its control field is zeroed whenever it empties.
  assign out_valid = main_valid_r;
  assign {out_ex_ctrl, out_mem_ctrl, out_pc, out_rs_val, out_rt_val, out_rd} = main_r;

`ifdef LOAD_USE_STALL_EN
  logic [7:0] stall_cnt_r;

  // Load-use hazard: a held load whose non-zero destination feeds the incoming instruction.
  always_comb begin
    stall_s = 1'b0;
    if (main_valid_r && main_r[ENT_W-4] && (out_rd != {REG_AW{1'b0}}) && in_valid &&
        ((in_rs == out_rd) || (in_rt == out_rd))) begin
      stall_s = 1'b1;
    end else begin
      stall_s = 1'b0;
    end
  end

  // Saturating count of stall cycles; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= 8'd0;
    end else if (stall_s && (stall_cnt_r != 8'hFF)) begin
      stall_cnt_r <= stall_cnt_r + 8'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;
`else
  logic unused_rs_rt_s;

  assign stall_s        = 1'b0;
  assign unused_rs_rt_s = ^{in_rs, in_rt};
`endif

  // Main entry: refill from skid first to keep order, else from the accepted input, else bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_r <= 1'b0;
      main_r       <= {ENT_W{1'b0}};
    end else if (flush) begin
      main_valid_r                <= 1'b0;
      main_r[ENT_W-1 -: CTRL_W]   <= {CTRL_W{1'b0}};
    end else if (main_free_s) begin
      if (skid_valid_r) begin
        main_valid_r <= 1'b1;
        main_r       <= skid_r;
      end else if (accept_s) begin
        main_valid_r <= 1'b1;
        main_r       <= in_ent_s;
      end else begin
        main_valid_r                <= 1'b0;
        main_r[ENT_W-1 -: CTRL_W]   <= {CTRL_W{1'b0}};
      end
    end else begin
      main_valid_r <= main_valid_r;
      main_r       <= main_r;
    end
  end

  // Skid entry: catches an accepted input that cannot go to main this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_valid_r <= 1'b0;
      skid_r       <= {ENT_W{1'b0}};
    end else if (flush) begin
      skid_valid_r <= 1'b0;
      skid_r       <= skid_r;
    end else if (main_free_s && skid_valid_r) begin
      skid_valid_r <= accept_s;
      skid_r       <= accept_s ? in_ent_s : skid_r;
    end else if (!main_free_s && accept_s) begin
      skid_valid_r <= 1'b1;
      skid_r       <= in_ent_s;
    end else begin
      skid_valid_r <= skid_valid_r;
      skid_r       <= skid_r;
    end
  end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard bench for id_ex_stage_reg: accepted inputs are queued, transfers out are popped and compared.
module tb_id_ex_stage_reg;

  typedef struct packed {
    logic [4:0]  ex;
    logic [6:0]  mem;
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  rd;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [4:0]  in_ex_ctrl, out_ex_ctrl;
  logic [6:0]  in_mem_ctrl, out_mem_ctrl;
  logic [31:0] in_pc, in_rs_val, in_rt_val, out_pc, out_rs_val, out_rt_val;
  logic [5:0]  in_rs, in_rt, in_rd, out_rd;
`ifdef LOAD_USE_STALL_EN
  logic [7:0]  stall_cnt;
`endif

  int   n_cmp = 0;
  int   n_bad = 0;
  ent_t exp_q[$];

  always #5 clk = ~clk;

  id_ex_stage_reg #(.DATA_W(32), .REG_AW(6)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ex_ctrl(in_ex_ctrl), .in_mem_ctrl(in_mem_ctrl), .in_pc(in_pc),
    .in_rs_val(in_rs_val), .in_rt_val(in_rt_val),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ex_ctrl(out_ex_ctrl), .out_mem_ctrl(out_mem_ctrl), .out_pc(out_pc),
    .out_rs_val(out_rs_val), .out_rt_val(out_rt_val), .out_rd(out_rd)
`ifdef LOAD_USE_STALL_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  // Scoreboard: sampled mid-cycle, between the bench's input updates and the next rising edge.
  always @(negedge clk) begin
    if (!rst_n || flush) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL scoreboard_unexpected got pc=%h ex=%h mem=%h required no output", out_pc, out_ex_ctrl, out_mem_ctrl);
        end else begin
          ent_t e;
          ent_t got;
          e   = exp_q.pop_front();
          got = '{out_ex_ctrl, out_mem_ctrl, out_pc, out_rs_val, out_rt_val, out_rd};
          if (got !== e) begin
            n_bad++;
            $display("FAIL scoreboard_entry got %h required %h", got, e);
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back('{in_ex_ctrl, in_mem_ctrl, in_pc, in_rs_val, in_rt_val, in_rd});
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [31:0] pc, input logic [4:0] ex, input logic [6:0] mem,
                        input logic [5:0] rs, input logic [5:0] rt, input logic [5:0] rd);
    in_valid    = v;
    in_pc       = pc;
    in_ex_ctrl  = ex;
    in_mem_ctrl = mem;
    in_rs_val   = pc ^ 32'hA5A5_0000;
    in_rt_val   = ~pc;
    in_rs       = rs;
    in_rt       = rt;
    in_rd       = rd;
  endtask

  task automatic test_reset;
    #3;
    n_cmp++;
    if (out_valid !== 1'b0 || out_ex_ctrl !== 5'd0 || out_mem_ctrl !== 7'd0 || out_pc !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_hold got v=%b ex=%h mem=%h pc=%h required all 0", out_valid, out_ex_ctrl, out_mem_ctrl, out_pc);
    end
    #9 rst_n = 1'b1;
    tick();
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_rd !== 6'd0 || out_rs_val !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_release got rdy=%b v=%b rd=%h a=%h required rdy=1 others 0", in_ready, out_valid, out_rd, out_rs_val);
    end
  endtask

  task automatic test_stream;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 32'h10 + 32'(4 * i), {3'(i + 1), 2'b01}, 7'h40 | 7'(i), 6'(20 + i), 6'(30 + i), 6'(1 + i));
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL stream_ready[%0d] got %b required 1", i, in_ready);
      end
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_pc !== 32'h10 + 32'(4 * i)) begin
        n_bad++;
        $display("FAIL stream_latency[%0d] got v=%b pc=%h required v=1 pc=%h", i, out_valid, out_pc, 32'h10 + 32'(4 * i));
      end
    end
    set_in(1'b0, 32'h0, 5'd0, 7'd0, 6'd0, 6'd0, 6'd0);
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || out_ex_ctrl !== 5'd0 || out_mem_ctrl !== 7'd0 || out_pc !== 32'h1C) begin
      n_bad++;
      $display("FAIL stream_bubble got v=%b ex=%h mem=%h pc=%h required 0 0 0 0000001c", out_valid, out_ex_ctrl, out_mem_ctrl, out_pc);
    end
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b0;
    set_in(1'b1, 32'h100, 5'b00101, 7'h41, 6'd10, 6'd11, 6'd12);
    tick();
    set_in(1'b1, 32'h104, 5'b01001, 7'h42, 6'd13, 6'd14, 6'd15);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_skid_ready got %b required 1", in_ready);
    end
    tick();
    set_in(1'b1, 32'h108, 5'b01101, 7'h43, 6'd16, 6'd17, 6'd18);
    n_cmp++;
    if (in_ready !== 1'b0 || out_pc !== 32'h100) begin
      n_bad++;
      $display("FAIL b2b_full got rdy=%b pc=%h required rdy=0 pc=00000100", in_ready, out_pc);
    end
    tick();
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_hold got rdy=%b v=%b required rdy=0 v=1", in_ready, out_valid);
    end
    out_ready = 1'b1;
    tick();
    n_cmp++;
    if (out_pc !== 32'h104 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_drain1 got pc=%h rdy=%b required pc=00000104 rdy=1", out_pc, in_ready);
    end
    tick();
    n_cmp++;
    if (out_pc !== 32'h108 || out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_drain2 got pc=%h v=%b required pc=00000108 v=1", out_pc, out_valid);
    end
    set_in(1'b0, 32'h0, 5'd0, 7'd0, 6'd0, 6'd0, 6'd0);
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_empty got v=%b required 0", out_valid);
    end
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    set_in(1'b1, 32'h200, 5'b00101, 7'h7F, 6'd1, 6'd2, 6'd3);
    tick();
    set_in(1'b1, 32'h204, 5'b01001, 7'h7F, 6'd4, 6'd5, 6'd6);
    tick();
    set_in(1'b1, 32'h208, 5'b01101, 7'h7F, 6'd7, 6'd8, 6'd9);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    set_in(1'b0, 32'h0, 5'd0, 7'd0, 6'd0, 6'd0, 6'd0);
    n_cmp++;
    if (out_valid !== 1'b0 || out_ex_ctrl !== 5'd0 || out_mem_ctrl !== 7'd0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_full got v=%b ex=%h mem=%h rdy=%b required 0 0 0 1", out_valid, out_ex_ctrl, out_mem_ctrl, in_ready);
    end
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    set_in(1'b1, 32'h300, 5'b00001, 7'h40, 6'd1, 6'd2, 6'd3);
    tick();
    set_in(1'b1, 32'h304, 5'b00001, 7'h48, 6'd4, 6'd5, 6'd6);
    flush = 1'b1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_accept_ready got %b required 1", in_ready);
    end
    tick();
    flush = 1'b0;
    set_in(1'b0, 32'h0, 5'd0, 7'd0, 6'd0, 6'd0, 6'd0);
    n_cmp++;
    if (out_valid !== 1'b0 || out_mem_ctrl !== 7'd0) begin
      n_bad++;
      $display("FAIL flush_discard got v=%b mem=%h required 0 0", out_valid, out_mem_ctrl);
    end
    out_ready = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_async_reset;
    out_ready = 1'b0;
    set_in(1'b1, 32'h400, 5'b10101, 7'h55, 6'd1, 6'd2, 6'd3);
    tick();
    set_in(1'b0, 32'h0, 5'd0, 7'd0, 6'd0, 6'd0, 6'd0);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_ex_ctrl !== 5'd0 || out_mem_ctrl !== 7'd0 || out_pc !== 32'd0 || out_rd !== 6'd0) begin
      n_bad++;
      $display("FAIL async_reset got v=%b ex=%h mem=%h pc=%h rd=%h required all 0", out_valid, out_ex_ctrl, out_mem_ctrl, out_pc, out_rd);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    set_in(1'b1, 32'h500, 5'b00001, 7'h40, 6'd1, 6'd2, 6'd3);
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_pc !== 32'h500) begin
      n_bad++;
      $display("FAIL restart got v=%b pc=%h required v=1 pc=00000500", out_valid, out_pc);
    end
    set_in(1'b0, 32'h0, 5'd0, 7'd0, 6'd0, 6'd0, 6'd0);
    tick();
  endtask

`ifdef LOAD_USE_STALL_EN
  task automatic test_load_r0;
    out_ready = 1'b1;
    set_in(1'b1, 32'h600, 5'b11110, 7'h60, 6'd1, 6'd2, 6'd0);
    tick();
    set_in(1'b1, 32'h604, 5'b00100, 7'h40, 6'd0, 6'd0, 6'd3);
    n_cmp++;
    if (in_ready !== 1'b1 || stall_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL load_r0_nostall got rdy=%b cnt=%0d required rdy=1 cnt=0", in_ready, stall_cnt);
    end
    tick();
    set_in(1'b0, 32'h0, 5'd0, 7'd0, 6'd0, 6'd0, 6'd0);
    tick();
    n_cmp++;
    if (stall_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL load_r0_cnt got %0d required 0", stall_cnt);
    end
  endtask

  task automatic test_load_use;
    out_ready = 1'b1;
    set_in(1'b1, 32'h700, 5'b11110, 7'h60, 6'd1, 6'd2, 6'd5);
    tick();
    set_in(1'b1, 32'h704, 5'b00100, 7'h40, 6'd5, 6'd7, 6'd9);
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL load_use_stall got rdy=%b required 0", in_ready);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || out_ex_ctrl !== 5'd0 || out_mem_ctrl !== 7'd0 || stall_cnt !== 8'd1 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL load_use_bubble got v=%b ex=%h mem=%h cnt=%0d rdy=%b required 0 0 0 1 1", out_valid, out_ex_ctrl, out_mem_ctrl, stall_cnt, in_ready);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_pc !== 32'h704 || stall_cnt !== 8'd1) begin
      n_bad++;
      $display("FAIL load_use_accept got v=%b pc=%h cnt=%0d required 1 00000704 1", out_valid, out_pc, stall_cnt);
    end
    set_in(1'b0, 32'h0, 5'd0, 7'd0, 6'd0, 6'd0, 6'd0);
    tick();
  endtask
`endif

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    set_in(1'b0, 32'h0, 5'd0, 7'd0, 6'd0, 6'd0, 6'd0);
    test_reset();
    test_stream();
    test_back_to_back();
    test_flush();
    test_async_reset();
`ifdef LOAD_USE_STALL_EN
    test_load_r0();
    test_load_use();
`endif
    out_ready = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain got %0d pending required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
